// File: rtl/mips_multicycle_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mips_multicycle_ctrl
//  Purpose  : Main control FSM of the multicycle MIPS datapath, with a
//             memory-ready stall handshake and a retired-instruction counter.
//  Revision : 1.0  initial release
// ============================================================================
module mips_multicycle_ctrl #(
    parameter int USE_MEM_READY = 1,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_src,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state_o
);

    localparam logic [3:0] c_FETCH  = 4'd0;
    localparam logic [3:0] c_DECODE = 4'd1;
    localparam logic [3:0] c_MEMADR = 4'd2;
    localparam logic [3:0] c_MEMRD  = 4'd3;
    localparam logic [3:0] c_MEMWB  = 4'd4;
    localparam logic [3:0] c_MEMWR  = 4'd5;
    localparam logic [3:0] c_EXEC   = 4'd6;
    localparam logic [3:0] c_ALUWB  = 4'd7;
    localparam logic [3:0] c_BRANCH = 4'd8;
    localparam logic [3:0] c_ADDIEX = 4'd9;
    localparam logic [3:0] c_ADDIWB = 4'd10;
    localparam logic [3:0] c_JUMP   = 4'd11;

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [3:0]       r_state;
    logic [3:0]       w_next;
    logic [CNT_W-1:0] r_retired;
    logic             w_ready;
    logic             w_retire;
    logic             w_legal;

    assign w_ready = (USE_MEM_READY != 0) ? mem_ready : 1'b1;
    assign w_legal = (opcode == c_OP_RTYPE) || (opcode == c_OP_J)  ||
                     (opcode == c_OP_BEQ)   || (opcode == c_OP_ADDI) ||
                     (opcode == c_OP_LW)    || (opcode == c_OP_SW);

    always_comb begin
        w_next = c_FETCH;
        case (r_state)
            c_FETCH:  w_next = w_ready ? c_DECODE : c_FETCH;
            c_DECODE: begin
                case (opcode)
                    c_OP_LW, c_OP_SW: w_next = c_MEMADR;
                    c_OP_RTYPE:       w_next = c_EXEC;
                    c_OP_BEQ:         w_next = c_BRANCH;
                    c_OP_ADDI:        w_next = c_ADDIEX;
                    c_OP_J:           w_next = c_JUMP;
                    default:          w_next = c_FETCH;
                endcase
            end
            c_MEMADR: w_next = (opcode == c_OP_LW) ? c_MEMRD : c_MEMWR;
            c_MEMRD:  w_next = w_ready ? c_MEMWB : c_MEMRD;
            c_MEMWR:  w_next = w_ready ? c_FETCH : c_MEMWR;
            c_EXEC:   w_next = c_ALUWB;
            c_ADDIEX: w_next = c_ADDIWB;
            default:  w_next = c_FETCH;
        endcase
    end

    // A store retires only once memory accepts it; other paths retire on their last state.
    always_comb begin
        case (r_state)
            c_MEMWB, c_ALUWB, c_BRANCH, c_ADDIWB, c_JUMP: w_retire = 1'b1;
            c_MEMWR:                                      w_retire = w_ready;
            default:                                      w_retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_FETCH;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) begin
                r_retired <= r_retired + c_CNT_ONE;
            end
        end
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 2'b00;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        illegal_op    = 1'b0;
        if (!reset) begin
            case (r_state)
                c_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = w_ready;
                    pc_write  = w_ready;
                end
                c_DECODE: begin
                    alu_src_b  = 2'b11;
                    illegal_op = ~w_legal;
                end
                c_MEMADR, c_ADDIEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                c_MEMRD: begin
                    i_or_d   = 1'b1;
                    mem_read = 1'b1;
                end
                c_MEMWB: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                end
                c_MEMWR: begin
                    i_or_d    = 1'b1;
                    mem_write = 1'b1;
                end
                c_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                c_ALUWB: begin
                    reg_dst   = 1'b1;
                    reg_write = 1'b1;
                end
                c_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_src        = 2'b01;
                end
                c_ADDIWB: reg_write = 1'b1;
                c_JUMP: begin
                    pc_write = 1'b1;
                    pc_src   = 2'b10;
                end
                default: ;
            endcase
        end
    end

    assign retired = r_retired;
    assign state_o = r_state;

endmodule
`default_nettype wire
